// File: rtl/hazard_pkg.sv
// Shared types and default latencies for the pipeline hazard scoreboard.
package hazard_pkg;

    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_LOAD = 2'd1,
        LAT_LONG = 2'd2
    } lat_cls_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } fsm_state_e;

    localparam int DEF_NREG     = 32;
    localparam int DEF_ALU_LAT  = 1;
    localparam int DEF_LOAD_LAT = 2;
    localparam int DEF_LONG_LAT = 3;

    function automatic int max_lat(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard scoreboard bundle: D-stage operand info in, stall/flush controls out.
interface hazard_scoreboard_if #(
    parameter int NREG = 32
);
    localparam int RW = $clog2(NREG);

    logic          validD;
    logic [RW-1:0] rsD;
    logic [RW-1:0] rtD;
    logic          rs_useD;
    logic          rt_useD;
    logic [RW-1:0] wregD;
    logic          regwriteD;
    logic [1:0]    lat_clsD;
    logic          branchD;
    logic          jrD;
    logic          div_busyE;
    logic          stallreq_from_if;
    logic          stallreq_from_mem;
    logic [31:0]   excepttypeM;

    logic stallF, stallD, stallE, stallM, stallW;
    logic flushF, flushD, flushE, flushM, flushW;
    logic flush_except;
    logic sb_busy;

    modport master (
        output validD, rsD, rtD, rs_useD, rt_useD, wregD, regwriteD, lat_clsD,
               branchD, jrD, div_busyE, stallreq_from_if, stallreq_from_mem, excepttypeM,
        input  stallF, stallD, stallE, stallM, stallW,
               flushF, flushD, flushE, flushM, flushW, flush_except, sb_busy
    );

    modport slave (
        input  validD, rsD, rtD, rs_useD, rt_useD, wregD, regwriteD, lat_clsD,
               branchD, jrD, div_busyE, stallreq_from_if, stallreq_from_mem, excepttypeM,
        output stallF, stallD, stallE, stallM, stallW,
               flushF, flushD, flushE, flushM, flushW, flush_except, sb_busy
    );

endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard slot: pending bit plus a countdown to bypass availability.
module sb_entry #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          set,
    input  logic [CW-1:0] set_cnt,
    input  logic          set_long,
    input  logic          tick,
    input  logic          hold,
    output logic          pend,
    output logic [CW-1:0] cnt
);

    logic long_q;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            pend   <= 1'b0;
            cnt    <= '0;
            long_q <= 1'b0;
        end else if (set) begin
            pend   <= 1'b1;
            cnt    <= set_cnt;
            long_q <= set_long;
        end else if (tick && pend) begin
            if (cnt == '0) begin
                pend <= 1'b0;
            end else if (!(long_q && hold && cnt == CW'(1))) begin
                // A busy divider pins the count at 1 so readers keep waiting on it.
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based stall/flush controller with exception drain/flush FSM.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG     = DEF_NREG,
    parameter int ALU_LAT  = DEF_ALU_LAT,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int LONG_LAT = DEF_LONG_LAT
) (
    input  logic                 clk,
    input  logic                 resetn,
    hazard_scoreboard_if.slave   bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]          perf_raw_cnt,
    output logic [31:0]          perf_br_cnt,
    output logic [31:0]          perf_flush_cnt
`endif
);

    localparam int RW   = $clog2(NREG);
    localparam int MAXL = max_lat(ALU_LAT, LOAD_LAT, LONG_LAT);
    localparam int CW   = (MAXL < 1) ? 1 : $clog2(MAXL + 1);

    fsm_state_e    state;
    logic [NREG-1:0] pend;
    logic [CW-1:0] cnt [NREG];

    logic          iss;
    logic [CW-1:0] iss_lat;
    logic          iss_long;
    logic          rs_pend, rt_pend;
    logic [CW-1:0] rs_cnt, rt_cnt;
    logic          raw, brs;
    logic          stall_d, stall_e;
    logic          flush_st;
    logic          exc_any;

    assign flush_st = (state == FLUSH);
    assign exc_any  = |bus.excepttypeM;

    always_comb begin
        iss_lat  = CW'(LONG_LAT);
        iss_long = 1'b1;
        if (bus.lat_clsD == LAT_ALU) begin
            iss_lat  = CW'(ALU_LAT);
            iss_long = 1'b0;
        end else if (bus.lat_clsD == LAT_LOAD) begin
            iss_lat  = CW'(LOAD_LAT);
            iss_long = 1'b0;
        end
    end

    assign rs_pend = bus.rs_useD & pend[bus.rsD];
    assign rt_pend = bus.rt_useD & pend[bus.rtD];
    assign rs_cnt  = cnt[bus.rsD];
    assign rt_cnt  = cnt[bus.rtD];

    // Count 1 means the result is on the E->D bypass next cycle; branches resolve in D so they cannot use it.
    assign raw = (rs_pend & (rs_cnt > CW'(1))) | (rt_pend & (rt_cnt > CW'(1)));
    assign brs = (bus.branchD | bus.jrD) &
                 ((rs_pend & (rs_cnt != '0)) | (rt_pend & (rt_cnt != '0)));

    assign stall_d = raw | brs | bus.div_busyE | bus.stallreq_from_if |
                     bus.stallreq_from_mem | (state != RUN);
    assign stall_e = bus.div_busyE | bus.stallreq_from_mem;

    assign iss = bus.validD & ~stall_d & ~flush_st & bus.regwriteD & (bus.wregD != '0);

    assign pend[0] = 1'b0;
    assign cnt[0]  = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_entry
        sb_entry #(.CW(CW)) u_entry (
            .clk     (clk),
            .resetn  (resetn),
            .clear   (flush_st),
            .set     (iss && (bus.wregD == RW'(i))),
            .set_cnt (iss_lat),
            .set_long(iss_long),
            .tick    (~bus.stallreq_from_mem),
            .hold    (bus.div_busyE),
            .pend    (pend[i]),
            .cnt     (cnt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (exc_any) state <= bus.stallreq_from_mem ? DRAIN : FLUSH;
                DRAIN:   if (!bus.stallreq_from_mem) state <= FLUSH;
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign bus.stallF       = resetn & stall_d;
    assign bus.stallD       = resetn & stall_d;
    assign bus.stallE       = resetn & stall_e;
    assign bus.stallM       = resetn & bus.stallreq_from_mem;
    assign bus.stallW       = 1'b0;
    assign bus.flushF       = ~resetn | flush_st;
    assign bus.flushD       = ~resetn | flush_st;
    assign bus.flushE       = ~resetn | flush_st | ((raw | brs) & ~stall_e);
    assign bus.flushM       = ~resetn | flush_st;
    assign bus.flushW       = ~resetn | flush_st | bus.stallreq_from_mem;
    assign bus.flush_except = resetn & flush_st;
    assign bus.sb_busy      = resetn & (|pend);

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_raw_cnt   <= '0;
            perf_br_cnt    <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (raw)      perf_raw_cnt   <= perf_raw_cnt + 32'd1;
            if (brs)      perf_br_cnt    <= perf_br_cnt + 32'd1;
            if (flush_st) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard (default latencies 1/2/3).
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NREG(32)) bus ();

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_raw_cnt, perf_br_cnt, perf_flush_cnt;
`endif

    hazard_scoreboard #(
        .NREG    (32),
        .ALU_LAT (1),
        .LOAD_LAT(2),
        .LONG_LAT(3)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
`ifdef HAZARD_PERF_EN
        ,
        .perf_raw_cnt  (perf_raw_cnt),
        .perf_br_cnt   (perf_br_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, wreg;
        logic        rsu, rtu, rw;
        logic [1:0]  cls;
        logic        br, jr, busy, ifs, mem;
        logic [31:0] exc;
        logic        e_sD, e_sE, e_sM, e_fF, e_fE, e_fW, e_fx, e_sb;
    } vec_t;

    // Output order: stallF stallD stallE stallM stallW flushF flushD flushE flushM flushW flush_except sb_busy
    localparam logic [11:0] RST_EXP = 12'b00000_11111_0_0;

    vec_t tbl [64];
    int unsigned n_vec = 0;

    function automatic vec_t ins(int valid, int rs, int rsu, int rt, int rtu,
                                 int wreg, int rw, int cls, int br, int jr);
        vec_t v;
        v = '{default: '0};
        v.valid = 1'(valid); v.rs = 5'(rs); v.rsu = 1'(rsu);
        v.rt = 5'(rt); v.rtu = 1'(rtu); v.wreg = 5'(wreg);
        v.rw = 1'(rw); v.cls = 2'(cls); v.br = 1'(br); v.jr = 1'(jr);
        return v;
    endfunction

    function automatic vec_t nop();
        return ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t side(vec_t v, int busy, int ifs, int mem, logic [31:0] exc);
        vec_t r;
        r = v;
        r.busy = 1'(busy); r.ifs = 1'(ifs); r.mem = 1'(mem); r.exc = exc;
        return r;
    endfunction

    function automatic vec_t hz(vec_t v, int sd, int fe, int sb);
        vec_t r;
        r = v;
        r.e_sD = 1'(sd); r.e_fE = 1'(fe); r.e_sb = 1'(sb);
        r.e_sE = v.busy | v.mem; r.e_sM = v.mem; r.e_fW = v.mem;
        r.e_fF = 1'b0; r.e_fx = 1'b0;
        return r;
    endfunction

    function automatic logic [11:0] exp_of(vec_t v);
        return {v.e_sD, v.e_sD, v.e_sE, v.e_sM, 1'b0,
                v.e_fF, v.e_fF, v.e_fE, v.e_fF, v.e_fW, v.e_fx, v.e_sb};
    endfunction

    task automatic add(vec_t v);
        tbl[n_vec] = v;
        n_vec++;
    endtask

    task automatic drive(vec_t v);
        bus.validD = v.valid; bus.rsD = v.rs; bus.rtD = v.rt;
        bus.rs_useD = v.rsu; bus.rt_useD = v.rtu; bus.wregD = v.wreg;
        bus.regwriteD = v.rw; bus.lat_clsD = v.cls; bus.branchD = v.br; bus.jrD = v.jr;
        bus.div_busyE = v.busy; bus.stallreq_from_if = v.ifs;
        bus.stallreq_from_mem = v.mem; bus.excepttypeM = v.exc;
    endtask

    task automatic check(string tag, logic [11:0] exp);
        logic [11:0] act;
        act = {bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.stallW,
               bus.flushF, bus.flushD, bus.flushE, bus.flushM, bus.flushW,
               bus.flush_except, bus.sb_busy};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (sF sD sE sM sW fF fD fE fM fW fx busy)",
                     tag, act, exp);
        end
    endtask

    task automatic run(vec_t v, string tag);
        drive(v);
        #2;
        check(tag, exp_of(v));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;

        // load-use, one cycle
        add(hz(ins(1, 0, 0, 0, 0, 2, 1, 1, 0, 0), 0, 0, 0));
        add(hz(ins(1, 2, 1, 0, 1, 3, 1, 0, 0, 0), 1, 1, 1));
        add(hz(ins(1, 2, 1, 0, 1, 3, 1, 0, 0, 0), 0, 0, 1));
        add(hz(nop(), 0, 0, 1));
        add(hz(nop(), 0, 0, 0));
        // ALU result feeding a branch
        add(hz(ins(1, 0, 0, 0, 0, 2, 1, 0, 0, 0), 0, 0, 0));
        add(hz(ins(1, 2, 1, 0, 1, 0, 0, 0, 1, 0), 1, 1, 1));
        add(hz(ins(1, 2, 1, 0, 1, 0, 0, 0, 1, 0), 0, 0, 0));
        // ALU -> ALU is bypassed
        add(hz(ins(1, 0, 0, 0, 0, 6, 1, 0, 0, 0), 0, 0, 0));
        add(hz(ins(1, 6, 1, 0, 0, 7, 1, 0, 0, 0), 0, 0, 1));
        add(hz(nop(), 0, 0, 1));
        add(hz(nop(), 0, 0, 0));
        // write to $0 is never tracked
        add(hz(ins(1, 0, 0, 0, 0, 0, 1, 1, 0, 0), 0, 0, 0));
        add(hz(ins(1, 0, 1, 0, 1, 8, 0, 0, 0, 0), 0, 0, 0));
        // re-issue to $5 in its retire cycle
        add(hz(ins(1, 0, 0, 0, 0, 5, 1, 0, 0, 0), 0, 0, 0));
        add(hz(ins(1, 0, 0, 0, 0, 5, 1, 1, 0, 0), 0, 0, 1));
        add(hz(ins(1, 5, 1, 0, 0, 0, 0, 0, 0, 0), 1, 1, 1));
        add(hz(ins(1, 5, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1));
        add(hz(nop(), 0, 0, 0));
        // RAW via rt
        add(hz(ins(1, 0, 0, 0, 0, 9, 1, 1, 0, 0), 0, 0, 0));
        add(hz(ins(1, 9, 0, 9, 1, 0, 0, 0, 0, 0), 1, 1, 1));
        add(hz(ins(1, 9, 0, 9, 1, 0, 0, 0, 0, 0), 0, 0, 1));
        add(hz(nop(), 0, 0, 0));
        // unused sources do not stall
        add(hz(ins(1, 0, 0, 0, 0, 10, 1, 1, 0, 0), 0, 0, 0));
        add(hz(ins(1, 10, 0, 10, 0, 0, 0, 0, 0, 0), 0, 0, 1));
        add(hz(nop(), 0, 0, 1));
        add(hz(nop(), 0, 0, 0));
        // invalid D instruction is not recorded
        add(hz(ins(0, 0, 0, 0, 0, 11, 1, 1, 0, 0), 0, 0, 0));
        add(hz(ins(1, 11, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0));
        // reserved class behaves as long-op (3 cycles)
        add(hz(ins(1, 0, 0, 0, 0, 12, 1, 3, 0, 0), 0, 0, 0));
        add(hz(ins(1, 12, 1, 0, 0, 0, 0, 0, 0, 0), 1, 1, 1));
        add(hz(ins(1, 12, 1, 0, 0, 0, 0, 0, 0, 0), 1, 1, 1));
        add(hz(ins(1, 12, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1));
        add(hz(nop(), 0, 0, 0));

        drive(nop());
        repeat (2) @(posedge clk);
        #1;
        check("reset", RST_EXP);
        resetn = 1'b1;

        for (int unsigned k = 0; k < n_vec; k++) run(tbl[k], $sformatf("vec%0d", k));

        // memory stall freezes countdown; raw behind stallE gives no bubble
        run(hz(ins(1, 0, 0, 0, 0, 2, 1, 1, 0, 0), 0, 0, 0), "frz_lw");
        for (int i = 0; i < 2; i++)
            run(hz(side(ins(1, 2, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0), 1, 0, 1), $sformatf("frz_mem%0d", i));
        run(hz(ins(1, 2, 1, 0, 0, 0, 0, 0, 0, 0), 1, 1, 1), "frz_raw");
        run(hz(ins(1, 2, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1), "frz_go");
        run(hz(nop(), 0, 0, 0), "frz_idle");
        run(hz(side(nop(), 0, 1, 0, 0), 1, 0, 0), "if_stall");

        // div $4 with 10 busy cycles, jr $4 waits for busy drop plus one
        run(hz(ins(1, 0, 0, 0, 0, 4, 1, 2, 0, 0), 0, 0, 0), "div_iss");
        for (int i = 0; i < 10; i++)
            run(hz(side(ins(1, 4, 1, 0, 0, 0, 0, 0, 0, 1), 1, 0, 0, 0), 1, 0, 1), $sformatf("div_busy%0d", i));
        run(hz(ins(1, 4, 1, 0, 0, 0, 0, 0, 0, 1), 1, 1, 1), "div_last");
        run(hz(ins(1, 4, 1, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0), "div_go");

        // reset asserted while stalled
        run(hz(ins(1, 0, 0, 0, 0, 2, 1, 1, 0, 0), 0, 0, 0), "rst_lw");
        run(hz(ins(1, 2, 1, 0, 0, 0, 0, 0, 0, 0), 1, 1, 1), "rst_stall");
        drive(ins(1, 2, 1, 0, 0, 0, 0, 0, 0, 0));
        resetn = 1'b0;
        #2;
        check("rst_mid", RST_EXP);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        run(hz(ins(1, 2, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0), "rst_after");

        // exception under memory stall: drain 3 cycles, then one flush cycle
        run(hz(ins(1, 0, 0, 0, 0, 7, 1, 2, 0, 0), 0, 0, 0), "exc_div");
        for (int i = 0; i < 3; i++)
            run(hz(side(nop(), 0, 0, 1, 32'h10), 1, 0, 1), $sformatf("exc_mem%0d", i));
        run(hz(side(nop(), 0, 0, 0, 32'h10), 1, 0, 1), "exc_drain_end");
        v = hz(side(ins(1, 0, 0, 0, 0, 13, 1, 1, 0, 0), 0, 0, 0, 32'h10), 1, 1, 1);
        v.e_fF = 1'b1; v.e_fW = 1'b1; v.e_fx = 1'b1;
        run(v, "exc_flush");
        run(hz(nop(), 0, 0, 0), "exc_after");
        run(hz(ins(1, 13, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0), "exc_noiss");

`ifdef HAZARD_PERF_EN
        n_tests++;
        if (perf_flush_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL perf_flush: got %0d required 1", perf_flush_cnt);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
